// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver: synchronises and filters the PS/2 lines, frames and checks bytes,
// and folds make/break/extended prefixes into the 11-bit toggle-based ps2_key event word.
module ps2_kbd_rx #(
  parameter int FILTER  = 8,
  parameter int TIMEOUT = 49152
) (
  input  logic        clk_sys,
  input  logic        RESET,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [10:0] ps2_key,
  output logic        frame_err,
  output logic        busy
);

  localparam int FCW = $clog2(FILTER + 1);
  localparam int TCW = $clog2(TIMEOUT + 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DATA   = 2'd1;
  localparam logic [1:0] ST_PARITY = 2'd2;
  localparam logic [1:0] ST_STOP   = 2'd3;

  logic           clk_s1_q, clk_s1_d, clk_s2_q, clk_s2_d;
  logic           dat_s1_q, dat_s1_d, dat_s2_q, dat_s2_d;
  logic           filt_q, filt_d;
  logic [FCW-1:0] filt_cnt_q, filt_cnt_d;
  logic           fall;
  logic [1:0]     state_q, state_d;
  logic [2:0]     bit_cnt_q, bit_cnt_d;
  logic [7:0]     shift_q, shift_d;
  logic           par_q, par_d;
  logic [TCW-1:0] to_cnt_q, to_cnt_d;
  logic           byte_vld_q, byte_vld_d;
  logic           frame_err_q, frame_err_d;
  logic           ext_q, ext_d, brk_q, brk_d;
  logic [2:0]     skip_q, skip_d;
  logic [10:0]    key_q, key_d;

  // Line synchronisers and glitch filter; fall strobes in the cycle before filt_q drops.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    clk_s1_d   = ps2_clk;
    clk_s2_d   = clk_s1_q;
    dat_s1_d   = ps2_data;
    dat_s2_d   = dat_s1_q;
    filt_d     = filt_q;
    filt_cnt_d = '0;
    if (clk_s2_q != filt_q) begin
      if (filt_cnt_q == FCW'(FILTER - 1)) filt_d = clk_s2_q;
      else                                filt_cnt_d = filt_cnt_q + 1'b1;
    end
    fall = filt_q & ~filt_d;
  end

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    par_d       = par_q;
    byte_vld_d  = 1'b0;
    frame_err_d = 1'b0;
    to_cnt_d    = (state_q == ST_IDLE || fall) ? '0 : to_cnt_q + 1'b1;

    if (fall) begin
      unique case (state_q)
        ST_IDLE: begin
          if (!dat_s2_q) begin
            state_d   = ST_DATA;
            bit_cnt_d = '0;
          end
        end
        ST_DATA: begin
          shift_d   = {dat_s2_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == 3'd7) state_d = ST_PARITY;
        end
        ST_PARITY: begin
          par_d   = dat_s2_q;
          state_d = ST_STOP;
        end
        ST_STOP: begin
          if (dat_s2_q && (^{shift_q, par_q})) byte_vld_d  = 1'b1;
          else                                 frame_err_d = 1'b1;
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end else if (state_q != ST_IDLE && to_cnt_q == TCW'(TIMEOUT - 1)) begin
      state_d     = ST_IDLE;
      frame_err_d = 1'b1;
    end
  end

  // Byte decode runs one cycle after a good stop bit; E1 swallows the rest of Pause.
  always_comb begin
    ext_d  = ext_q;
    brk_d  = brk_q;
    skip_d = skip_q;
    key_d  = key_q;
    if (frame_err_d) begin
      ext_d  = 1'b0;
      brk_d  = 1'b0;
      skip_d = '0;
    end else if (byte_vld_q) begin
      if (skip_q != 3'd0) begin
        skip_d = skip_q - 1'b1;
      end else begin
        unique case (shift_q)
          8'hE1: skip_d = 3'd7;
          8'hE0: ext_d  = 1'b1;
          8'hF0: brk_d  = 1'b1;
          8'hFA, 8'hAA, 8'hEE, 8'hFE, 8'h00, 8'hFF: begin
          end
          default: begin
            key_d = {~key_q[10], ~brk_q, ext_q, shift_q};
            ext_d = 1'b0;
            brk_d = 1'b0;
          end
        endcase
      end
    end
  end

  // NOTE: state is updated only with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_sys) begin
    if (RESET) begin
      clk_s1_q    <= 1'b1;
      clk_s2_q    <= 1'b1;
      dat_s1_q    <= 1'b1;
      dat_s2_q    <= 1'b1;
      filt_q      <= 1'b1;
      filt_cnt_q  <= '0;
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      par_q       <= 1'b0;
      to_cnt_q    <= '0;
      byte_vld_q  <= 1'b0;
      frame_err_q <= 1'b0;
      ext_q       <= 1'b0;
      brk_q       <= 1'b0;
      skip_q      <= '0;
      key_q       <= '0;
    end else begin
      clk_s1_q    <= clk_s1_d;
      clk_s2_q    <= clk_s2_d;
      dat_s1_q    <= dat_s1_d;
      dat_s2_q    <= dat_s2_d;
      filt_q      <= filt_d;
      filt_cnt_q  <= filt_cnt_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      par_q       <= par_d;
      to_cnt_q    <= to_cnt_d;
      byte_vld_q  <= byte_vld_d;
      frame_err_q <= frame_err_d;
      ext_q       <= ext_d;
      brk_q       <= brk_d;
      skip_q      <= skip_d;
      key_q       <= key_d;
    end
  end

  assign ps2_key   = key_q;
  assign frame_err = frame_err_q;
  assign busy      = (state_q != ST_IDLE);

endmodule
